// File: rtl/wd_defs.sv
// Shared constants, state encoding and helpers for the WD-style ID field path.
// Used by the ID sequencer and the CRC engine (and later the data-field path).
package wd_defs;

    localparam logic [7:0]  GAP_VAL  = 8'h4E;
    localparam logic [7:0]  AM_VAL   = 8'hA1;
    localparam logic [7:0]  MARK_FE  = 8'hFE;
    localparam logic [7:0]  MARK_FF  = 8'hFF;
    localparam logic [7:0]  MARK_FC  = 8'hFC;
    localparam logic [7:0]  MARK_FD  = 8'hFD;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [3:0] {
        ST_HUNT      = 4'd0,
        ST_COUNT_GAP = 4'd1,
        ST_WAIT_AM   = 4'd2,
        ST_AWAIT_ID  = 4'd3,
        ST_CYL       = 4'd4,
        ST_HEAD      = 4'd5,
        ST_SEC       = 4'd6,
        ST_CRC_HI    = 4'd7,
        ST_CRC_LO    = 4'd8
    } wd_state_t;

    // CCITT, MSB-first, one whole byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Returns {legal, cylinder bits [9:8]} for an ID mark byte.
    function automatic logic [2:0] mark_decode(input logic [7:0] b);
        logic [2:0] r;
        case (b)
            MARK_FE: r = 3'b1_00;
            MARK_FF: r = 3'b1_01;
            MARK_FC: r = 3'b1_10;
            MARK_FD: r = 3'b1_11;
            default: r = 3'b0_00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wd_crc16.sv
// Byte-parallel CRC-16-CCITT register with preset (init) and fold (en) controls.
// init and en together fold the byte into a freshly preset register.
module wd_crc16
    import wd_defs::*;
#(
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_base;
    logic [15:0] crc_next;

    always_comb begin
        crc_base = init ? CRC_INIT : crc_reg;
        crc_next = en ? crc16_byte(crc_base, data) : crc_base;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            crc_reg <= CRC_INIT;
        end else begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/wd_id_sequencer.sv
// Qualifies a 4E gap run, waits for the A1 address mark and parses the WD ID field,
// reporting the decoded fields and a CRC verdict one clock after the last CRC byte.
module wd_id_sequencer
    import wd_defs::*;
#(
    parameter int          MIN_GAP    = 4,
    parameter int          AM_TIMEOUT = 16,
    parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        byte_strobe,
    input  logic [7:0]  byte_buffer,
    input  logic        gap_sync,
    input  logic        am_detect,
    output logic        searching,
    output logic        hdr_valid,
    output logic        hdr_crc_ok,
    output logic [9:0]  hdr_cyl,
    output logic [2:0]  hdr_head,
    output logic [1:0]  hdr_size,
    output logic        hdr_bad,
    output logic [7:0]  hdr_sec,
    output logic        id_error
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam int TO_W  = $clog2(AM_TIMEOUT);

    wd_state_t        state_reg, state_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;

    // Shadow copies of the field bytes; exported only when the field completes.
    logic [1:0]       mark_hi_reg, mark_hi_next;
    logic [7:0]       cyl_reg, cyl_next;
    logic [5:0]       head_reg, head_next;
    logic [7:0]       sec_reg, sec_next;

    logic             hdr_valid_reg, hdr_valid_next;
    logic             id_error_reg, id_error_next;
    logic             hdr_crc_ok_reg, hdr_crc_ok_next;
    logic [9:0]       hdr_cyl_reg, hdr_cyl_next;
    logic [2:0]       hdr_head_reg, hdr_head_next;
    logic [1:0]       hdr_size_reg, hdr_size_next;
    logic             hdr_bad_reg, hdr_bad_next;
    logic [7:0]       hdr_sec_reg, hdr_sec_next;

    logic             crc_init;
    logic             crc_en;
    logic [15:0]      crc;
    logic [2:0]       mark_info;

    wd_crc16 #(
        .CRC_INIT (CRC_INIT)
    ) u_crc (
        .clk_50 (clk_50),
        .reset  (reset),
        .init   (crc_init),
        .en     (crc_en),
        .data   (byte_buffer),
        .crc    (crc)
    );

    assign mark_info = mark_decode(byte_buffer);

    always_comb begin
        state_next      = state_reg;
        gap_cnt_next    = gap_cnt_reg;
        to_cnt_next     = to_cnt_reg;
        mark_hi_next    = mark_hi_reg;
        cyl_next        = cyl_reg;
        head_next       = head_reg;
        sec_next        = sec_reg;
        hdr_valid_next  = 1'b0;
        id_error_next   = 1'b0;
        hdr_crc_ok_next = hdr_crc_ok_reg;
        hdr_cyl_next    = hdr_cyl_reg;
        hdr_head_next   = hdr_head_reg;
        hdr_size_next   = hdr_size_reg;
        hdr_bad_next    = hdr_bad_reg;
        hdr_sec_next    = hdr_sec_reg;
        crc_init        = 1'b0;
        crc_en          = 1'b0;

        if (byte_strobe) begin
            case (state_reg)
                ST_HUNT: begin
                    if (gap_sync) begin
                        state_next   = ST_COUNT_GAP;
                        gap_cnt_next = GAP_W'(1);
                    end
                end
                ST_COUNT_GAP: begin
                    if (am_detect && (gap_cnt_reg >= GAP_W'(MIN_GAP))) begin
                        state_next = ST_AWAIT_ID;
                        crc_init   = 1'b1;
                        crc_en     = 1'b1;
                    end else if (gap_sync) begin
                        if ((gap_cnt_reg + GAP_W'(1)) >= GAP_W'(MIN_GAP)) begin
                            state_next   = ST_WAIT_AM;
                            gap_cnt_next = GAP_W'(MIN_GAP);
                            to_cnt_next  = '0;
                            crc_init     = 1'b1;
                        end else begin
                            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                        end
                    end else begin
                        state_next = ST_HUNT;
                    end
                end
                ST_WAIT_AM: begin
                    if (am_detect) begin
                        state_next = ST_AWAIT_ID;
                        crc_init   = 1'b1;
                        crc_en     = 1'b1;
                    end else if (to_cnt_reg == TO_W'(AM_TIMEOUT - 1)) begin
                        state_next    = ST_HUNT;
                        id_error_next = 1'b1;
                    end else begin
                        to_cnt_next = to_cnt_reg + TO_W'(1);
                    end
                end
                ST_AWAIT_ID: begin
                    if (am_detect) begin
                        crc_en = 1'b1;
                    end else if (mark_info[2]) begin
                        state_next   = ST_CYL;
                        mark_hi_next = mark_info[1:0];
                        crc_en       = 1'b1;
                    end else begin
                        state_next    = ST_HUNT;
                        id_error_next = 1'b1;
                    end
                end
                ST_CYL: begin
                    state_next = ST_HEAD;
                    cyl_next   = byte_buffer;
                    crc_en     = 1'b1;
                end
                ST_HEAD: begin
                    state_next = ST_SEC;
                    head_next  = {byte_buffer[7:5], byte_buffer[2:0]};
                    crc_en     = 1'b1;
                end
                ST_SEC: begin
                    state_next = ST_CRC_HI;
                    sec_next   = byte_buffer;
                    crc_en     = 1'b1;
                end
                ST_CRC_HI: begin
                    state_next = ST_CRC_LO;
                    crc_en     = 1'b1;
                end
                ST_CRC_LO: begin
                    // The verdict needs the post-fold residue in this same cycle.
                    state_next      = ST_HUNT;
                    crc_en          = 1'b1;
                    hdr_valid_next  = 1'b1;
                    hdr_crc_ok_next = (crc16_byte(crc, byte_buffer) == 16'h0000);
                    hdr_cyl_next    = {mark_hi_reg, cyl_reg};
                    hdr_bad_next    = head_reg[5];
                    hdr_size_next   = head_reg[4:3];
                    hdr_head_next   = head_reg[2:0];
                    hdr_sec_next    = sec_reg;
                end
                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end

        if (state_next == ST_HUNT) begin
            gap_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_reg      <= ST_HUNT;
            gap_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            mark_hi_reg    <= '0;
            cyl_reg        <= '0;
            head_reg       <= '0;
            sec_reg        <= '0;
            hdr_valid_reg  <= 1'b0;
            id_error_reg   <= 1'b0;
            hdr_crc_ok_reg <= 1'b0;
            hdr_cyl_reg    <= '0;
            hdr_head_reg   <= '0;
            hdr_size_reg   <= '0;
            hdr_bad_reg    <= 1'b0;
            hdr_sec_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            gap_cnt_reg    <= gap_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            mark_hi_reg    <= mark_hi_next;
            cyl_reg        <= cyl_next;
            head_reg       <= head_next;
            sec_reg        <= sec_next;
            hdr_valid_reg  <= hdr_valid_next;
            id_error_reg   <= id_error_next;
            hdr_crc_ok_reg <= hdr_crc_ok_next;
            hdr_cyl_reg    <= hdr_cyl_next;
            hdr_head_reg   <= hdr_head_next;
            hdr_size_reg   <= hdr_size_next;
            hdr_bad_reg    <= hdr_bad_next;
            hdr_sec_reg    <= hdr_sec_next;
        end
    end

    assign searching  = (state_reg == ST_HUNT) || (state_reg == ST_COUNT_GAP) ||
                        (state_reg == ST_WAIT_AM);
    assign hdr_valid  = hdr_valid_reg;
    assign id_error   = id_error_reg;
    assign hdr_crc_ok = hdr_crc_ok_reg;
    assign hdr_cyl    = hdr_cyl_reg;
    assign hdr_head   = hdr_head_reg;
    assign hdr_size   = hdr_size_reg;
    assign hdr_bad    = hdr_bad_reg;
    assign hdr_sec    = hdr_sec_reg;

endmodule

// File: tb/tb_wd_id_sequencer.sv
// Scenario-driven bench: each frame's expected outcome and header fields are derived from
// the frame contents (gap length, mark code, CRC computed bit-serially) rather than the FSM.
module tb_wd_id_sequencer;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic       byte_strobe = 1'b0;
    logic [7:0] byte_buffer = 8'h00;
    logic       gap_sync = 1'b0;
    logic       am_detect = 1'b0;
    logic       searching, hdr_valid, hdr_crc_ok, hdr_bad, id_error;
    logic [9:0] hdr_cyl;
    logic [2:0] hdr_head;
    logic [1:0] hdr_size;
    logic [7:0] hdr_sec;

    int n_checks = 0;
    int n_pass = 0;

    // Expected exported header (last reported field, or zero after reset).
    logic [9:0] m_cyl = '0;
    logic [2:0] m_head = '0;
    logic [1:0] m_size = '0;
    logic       m_bad = 1'b0;
    logic [7:0] m_sec = '0;
    logic       m_ok = 1'b0;

    wd_id_sequencer dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .byte_strobe (byte_strobe),
        .byte_buffer (byte_buffer),
        .gap_sync    (gap_sync),
        .am_detect   (am_detect),
        .searching   (searching),
        .hdr_valid   (hdr_valid),
        .hdr_crc_ok  (hdr_crc_ok),
        .hdr_cyl     (hdr_cyl),
        .hdr_head    (hdr_head),
        .hdr_size    (hdr_size),
        .hdr_bad     (hdr_bad),
        .hdr_sec     (hdr_sec),
        .id_error    (id_error)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] crc_fold(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int k = 7; k >= 0; k--) begin
            fb = c[15] ^ b[k];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic int mark_hi(input logic [7:0] b);
        case (b)
            8'hFE:   return 0;
            8'hFF:   return 1;
            8'hFC:   return 2;
            8'hFD:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check_fields(input string tag);
        check_val({tag, "_cyl"}, hdr_cyl, m_cyl);
        check_val({tag, "_head"}, hdr_head, m_head);
        check_val({tag, "_size"}, hdr_size, m_size);
        check_val({tag, "_bad"}, hdr_bad, m_bad);
        check_val({tag, "_sec"}, hdr_sec, m_sec);
        check_val({tag, "_crc_ok"}, hdr_crc_ok, m_ok);
    endtask

    // One strobed byte; pulses are checked one clock after the strobe, then during idle cycles.
    task automatic send_byte(input logic [7:0] b, input logic am, input logic exp_valid,
                             input logic exp_err, input logic exp_search);
        int idle;
        @(negedge clk_50);
        byte_buffer = b;
        gap_sync    = (b == 8'h4E);
        am_detect   = am;
        byte_strobe = 1'b1;
        @(posedge clk_50);
        #1;
        byte_strobe = 1'b0;
        $display("byte %02h am=%0b -> valid=%0b err=%0b search=%0b", b, am, hdr_valid, id_error, searching);
        check_val("hdr_valid", hdr_valid, exp_valid);
        check_val("id_error", id_error, exp_err);
        check_val("searching", searching, exp_search);
        if (exp_valid) check_fields("hdr");
        byte_buffer = 8'($urandom);
        gap_sync    = 1'($urandom);
        am_detect   = 1'($urandom);
        idle = $urandom_range(0, 2);
        for (int i = 0; i < idle; i++) begin
            @(posedge clk_50);
            #1;
            check_val("pulse_width", {hdr_valid, id_error}, 2'b00);
        end
        am_detect = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_50);
        reset = 1'b1;
        byte_strobe = 1'b0;
        @(posedge clk_50);
        #1;
        @(negedge clk_50);
        reset = 1'b0;
        m_cyl = '0; m_head = '0; m_size = '0; m_bad = 1'b0; m_sec = '0; m_ok = 1'b0;
        $display("reset -> valid=%0b err=%0b search=%0b", hdr_valid, id_error, searching);
        check_val("rst_pulses", {hdr_valid, id_error}, 2'b00);
        check_val("rst_searching", searching, 1'b1);
        check_fields("rst");
    endtask

    task automatic noise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom); while (b == 8'h4E);
            send_byte(b, (b == 8'hA1), 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic frame(input int gaps, input int syncs, input int n_a1, input logic [7:0] mark,
                         input logic [7:0] cyl, input logic [7:0] hd, input logic [7:0] sec,
                         input logic [7:0] lo_xor, input int abort_at);
        logic [15:0] c;
        logic [7:0]  fb [5];
        int          hi;
        for (int i = 0; i < gaps; i++) send_byte(8'h4E, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < syncs; i++) send_byte(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        c = 16'hFFFF;
        for (int i = 0; i < n_a1; i++) begin
            send_byte(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
            c = crc_fold(c, 8'hA1);
        end
        hi = mark_hi(mark);
        if (hi < 0) begin
            send_byte(mark, 1'b0, 1'b0, 1'b1, 1'b1);
            check_fields("hold_badmark");
            return;
        end
        send_byte(mark, 1'b0, 1'b0, 1'b0, 1'b0);
        c = crc_fold(crc_fold(crc_fold(crc_fold(c, mark), cyl), hd), sec);
        fb = '{cyl, hd, sec, c[15:8], c[7:0] ^ lo_xor};
        for (int i = 0; i < 5; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            if (i == 4) begin
                m_cyl  = {2'(hi), cyl};
                m_head = hd[2:0];
                m_size = hd[6:5];
                m_bad  = hd[7];
                m_sec  = sec;
                m_ok   = (lo_xor == 8'h00);
                send_byte(fb[i], 1'b0, 1'b1, 1'b0, 1'b1);
            end else begin
                send_byte(fb[i], 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic short_gap(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h4E, 1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_fields("hold_short");
    endtask

    // Four gap bytes reach the mark hunt; the 16th strobe there without a mark times out.
    task automatic timeout_run();
        for (int i = 0; i < 4; i++) send_byte(8'h4E, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) send_byte(8'h00, 1'b0, 1'b0, (i == 16), 1'b1);
        check_fields("hold_timeout");
    endtask

    initial begin
        logic [7:0] codes [4];
        logic [7:0] mk;
        int         kind, g;
        codes = '{8'hFE, 8'hFF, 8'hFC, 8'hFD};

        repeat (3) @(posedge clk_50);
        #1;
        check_val("reset_pulses", {hdr_valid, id_error}, 2'b00);
        check_val("reset_searching", searching, 1'b1);
        check_fields("reset");
        @(negedge clk_50);
        reset = 1'b0;

        frame(6, 2, 1, 8'hFE, 8'h05, 8'h02, 8'h11, 8'h00, -1);
        frame(6, 2, 1, 8'hFE, 8'h05, 8'h02, 8'h11, 8'h01, -1);
        short_gap(3);
        timeout_run();
        frame(4, 0, 1, 8'hFD, 8'h2A, 8'h01, 8'h09, 8'h00, -1);
        frame(4, 0, 1, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00, -1);
        frame(5, 1, 3, 8'hFE, 8'h21, 8'h04, 8'h03, 8'h00, 2);
        frame(4, 0, 1, 8'hFF, 8'h10, 8'h83, 8'h07, 8'h00, -1);

        for (int s = 0; s < 60; s++) begin
            noise($urandom_range(0, 2));
            kind = $urandom_range(0, 5);
            g = $urandom_range(4, 7);
            case (kind)
                0, 1: frame(g, $urandom_range(0, 14 - g), $urandom_range(1, 3),
                            codes[$urandom_range(0, 3)], 8'($urandom), 8'($urandom),
                            8'($urandom), 8'h00, -1);
                2: frame(g, $urandom_range(0, 14 - g), $urandom_range(1, 3),
                         codes[$urandom_range(0, 3)], 8'($urandom), 8'($urandom),
                         8'($urandom), 8'($urandom_range(1, 255)), -1);
                3: short_gap($urandom_range(1, 3));
                4: timeout_run();
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        do mk = 8'($urandom); while (mark_hi(mk) >= 0);
                        frame(g, 0, $urandom_range(1, 3), mk, 8'h00, 8'h00, 8'h00, 8'h00, -1);
                    end else begin
                        frame(g, 1, 1, codes[$urandom_range(0, 3)], 8'($urandom),
                              8'($urandom), 8'($urandom), 8'h00, $urandom_range(0, 4));
                    end
                end
            endcase
        end

        @(posedge clk_50);
        #1;
        check_val("final_pulses", {hdr_valid, id_error}, 2'b00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
